// File: rtl/pd_instr_queue_pkg.sv
// Shared types for the predecode -> decode instruction queue.
package pd_instr_queue_pkg;

    localparam int DEC_WIDTH = 4;
    localparam int PDQ_DEPTH = 16;

    typedef logic [$clog2(PDQ_DEPTH)-1:0] PDQIdx_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } PD_Instr;

endpackage

// File: rtl/pd_instr_queue_lane_compactor.sv
// Prefix popcount over lane valids: per-lane write offset and total lanes written.
module pd_instr_queue_lane_compactor #(
    parameter int NUM_IN = 4,
    parameter int OFF_W  = $clog2(NUM_IN + 1)
) (
    input  logic [NUM_IN-1:0]            valid_i,
    output logic [NUM_IN-1:0][OFF_W-1:0] offset_o,
    output logic [OFF_W-1:0]             n_in_o
);

    logic [OFF_W-1:0] run_s;

    // running count of valid lanes below each lane
    always_comb begin
        run_s    = '0;
        offset_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            offset_o[i] = run_s;
            run_s       = run_s + OFF_W'(valid_i[i]);
        end
        n_in_o = run_s;
    end

endmodule

// File: rtl/pd_instr_queue.sv
// Decoupling FIFO between predecode and decode: compacting enqueue, in-order group dequeue, flush.
module pd_instr_queue
    import pd_instr_queue_pkg::*;
#(
    parameter int NUM_IN  = DEC_WIDTH,
    parameter int NUM_OUT = DEC_WIDTH,
    parameter int DEPTH   = PDQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      IN_mispred,
    input  PD_Instr [NUM_IN-1:0]      IN_instrs,
    output logic                      OUT_ready,
    input  logic                      IN_decReady,
    output PD_Instr [NUM_OUT-1:0]     OUT_instrs,
    output logic [$clog2(DEPTH):0]    OUT_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = $clog2(NUM_IN + 1);

    PD_Instr                     mem_q [DEPTH];
    PD_Instr                     mem_d [DEPTH];
    logic [IDX_W-1:0]            head_q, head_d;
    logic [IDX_W-1:0]            tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CNT_W-1:0]            n_out_s;
    logic [NUM_IN-1:0]           lane_valid_s;
    logic [NUM_IN-1:0][OFF_W-1:0] lane_off_s;
    logic [OFF_W-1:0]            n_in_s;
    logic [IDX_W-1:0]            wr_idx_s;

    // gather per-lane valid bits for the compactor
    always_comb begin
        lane_valid_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            lane_valid_s[i] = IN_instrs[i].valid;
        end
    end

    pd_instr_queue_lane_compactor #(
        .NUM_IN (NUM_IN),
        .OFF_W  (OFF_W)
    ) u_compactor (
        .valid_i  (lane_valid_s),
        .offset_o (lane_off_s),
        .n_in_o   (n_in_s)
    );

    // dequeue group size: all presented lanes leave together or none do
    always_comb begin
        n_out_s = '0;
        if (IN_decReady && !IN_mispred) begin
            if (count_q >= CNT_W'(NUM_OUT)) begin
                n_out_s = CNT_W'(NUM_OUT);
            end else begin
                n_out_s = count_q;
            end
        end else begin
            n_out_s = '0;
        end
    end

    // next pointers, occupancy and storage writes; flush overrides everything
    always_comb begin
        mem_d    = mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        wr_idx_s = tail_q;
        if (IN_mispred) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + IDX_W'(n_out_s);
            tail_d  = tail_q + IDX_W'(n_in_s);
            count_d = count_q + CNT_W'(n_in_s) - n_out_s;
            for (int i = 0; i < NUM_IN; i++) begin
                wr_idx_s        = tail_q + IDX_W'(lane_off_s[i]);
                mem_d[wr_idx_s] = lane_valid_s[i] ? IN_instrs[i] : mem_d[wr_idx_s];
            end
        end
    end

    // control state; async clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // payload storage; contents are meaningless outside [head, head+count)
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // presentation: oldest NUM_OUT entries, validity derived from occupancy only
    always_comb begin
        OUT_instrs = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            OUT_instrs[i]       = mem_q[head_q + IDX_W'(i)];
            OUT_instrs[i].valid = (CNT_W'(i) < count_q) && !IN_mispred;
        end
        OUT_count = count_q;
        OUT_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2 * NUM_IN);
    end

endmodule
